// File: rtl/fmc_pkg.sv
// Shared types and timing defaults for the FMC-style SRAM bus master,
// its register-file responder and the bench.
package fmc_pkg;

    localparam int FMC_ADDR_W = 20;
    localparam int FMC_DATA_W = 16;

    localparam int FMC_ADDSET_DEF = 2;
    localparam int FMC_DATAST_DEF = 4;
    localparam int FMC_HOLD_DEF   = 1;
    localparam int FMC_TURN_DEF   = 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_TURN   = 3'd4
    } fmc_state_t;

    function automatic int fmc_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/fmc_phase_counter.sv
// Phase down-counter: reloads on state entry, counts to zero, flags done at zero.
module fmc_phase_counter #(
    parameter int CNT_W = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/fmc_bus_master.sv
// Single-word initiator for an asynchronous SRAM-style bus: turns read/write
// commands into SETUP/STROBE/HOLD/TURN timed cycles with registered pad outputs.
module fmc_bus_master
    import fmc_pkg::*;
#(
    parameter int ADDSET = FMC_ADDSET_DEF,
    parameter int DATAST = FMC_DATAST_DEF,
    parameter int HOLD   = FMC_HOLD_DEF,
    parameter int TURN   = FMC_TURN_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [FMC_ADDR_W-1:0] i_cmd_addr,
    input  logic [FMC_DATA_W-1:0] i_cmd_wdata,
    input  logic [1:0]            i_cmd_be,
    output logic                  o_rsp_valid,
    output logic [FMC_DATA_W-1:0] o_rsp_rdata,
    output logic [FMC_ADDR_W-1:0] o_bus_addr,
    output logic [FMC_DATA_W-1:0] o_bus_dout,
    input  logic [FMC_DATA_W-1:0] i_bus_din,
    output logic                  o_bus_doe,
    output logic                  o_bus_ne,
    output logic                  o_bus_noe,
    output logic                  o_bus_nwe,
    output logic [1:0]            o_bus_nbl
);

    if (ADDSET < 1 || DATAST < 1 || HOLD < 1 || TURN < 1) begin : g_param_err
        $error("fmc_bus_master: ADDSET, DATAST, HOLD and TURN must all be >= 1");
    end

    localparam int CNT_W = $clog2(fmc_max4(ADDSET, DATAST, HOLD, TURN)) + 1;
    localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(ADDSET - 1);
    localparam logic [CNT_W-1:0] L_STROBE = CNT_W'(DATAST - 1);
    localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] L_TURN   = CNT_W'(TURN - 1);

    fmc_state_t            r_state;
    fmc_state_t            w_state_next;
    logic                  r_write;
    logic [1:0]            r_be;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_load;
    logic [CNT_W-1:0]      w_load_val;
    logic                  w_write_sel;
    logic [1:0]            w_be_sel;
    logic                  w_active;
    logic                  w_ne;
    logic                  w_noe;
    logic                  w_nwe;
    logic                  w_doe;
    logic [1:0]            w_nbl;
    logic                  w_rsp_valid;

    assign o_cmd_ready = (r_state == S_IDLE) && !i_reset;
    assign w_accept    = i_cmd_valid && (r_state == S_IDLE);

    fmc_phase_counter #(.CNT_W(CNT_W)) u_phase_cnt (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (r_state != S_IDLE),
        .o_done     (w_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_state_next = S_SETUP;
            S_SETUP:  if (w_done)   w_state_next = S_STROBE;
            S_STROBE: if (w_done)   w_state_next = S_HOLD;
            S_HOLD:   if (w_done)   w_state_next = S_TURN;
            S_TURN:   if (w_done)   w_state_next = S_IDLE;
            default:                w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each pad
    // changes on the same edge as the state it belongs to.
    always_comb begin
        w_load      = (w_state_next != r_state);
        w_load_val  = '0;
        unique case (w_state_next)
            S_SETUP:  w_load_val = L_SETUP;
            S_STROBE: w_load_val = L_STROBE;
            S_HOLD:   w_load_val = L_HOLD;
            S_TURN:   w_load_val = L_TURN;
            default:  w_load_val = '0;
        endcase
        w_write_sel = w_accept ? i_cmd_write : r_write;
        w_be_sel    = w_accept ? i_cmd_be    : r_be;
        w_active    = (w_state_next == S_SETUP) || (w_state_next == S_STROBE) ||
                      (w_state_next == S_HOLD);
        w_ne        = !w_active;
        w_noe       = !((w_state_next == S_STROBE) && !w_write_sel);
        w_nwe       = !((w_state_next == S_STROBE) && w_write_sel);
        w_doe       = w_active && w_write_sel;
        w_nbl       = !w_active ? 2'b11 : (w_write_sel ? ~w_be_sel : 2'b00);
        w_rsp_valid = (w_state_next == S_TURN) && (r_state == S_HOLD);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_write     <= 1'b0;
            r_be        <= 2'b00;
            o_bus_addr  <= '0;
            o_bus_dout  <= '0;
            o_bus_ne    <= 1'b1;
            o_bus_noe   <= 1'b1;
            o_bus_nwe   <= 1'b1;
            o_bus_nbl   <= 2'b11;
            o_bus_doe   <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_write    <= i_cmd_write;
                r_be       <= i_cmd_be;
                o_bus_addr <= i_cmd_addr;
                if (i_cmd_write) o_bus_dout <= i_cmd_wdata;
            end
            o_bus_ne    <= w_ne;
            o_bus_noe   <= w_noe;
            o_bus_nwe   <= w_nwe;
            o_bus_nbl   <= w_nbl;
            o_bus_doe   <= w_doe;
            o_rsp_valid <= w_rsp_valid;
            // Sample the pads only once, at the end of the strobe window.
            if ((r_state == S_STROBE) && w_done && !r_write) begin
                o_rsp_rdata <= i_bus_din;
            end
        end
    end

endmodule

// File: doc/fmc_bus_master.md
Name: fmc_bus_master

Overview:
- Synchronous initiator for the asynchronous SRAM-style external memory bus (chip select, output enable, write enable, byte lanes, 20-bit address, 16-bit data).
- Converts single-word read/write commands from on-chip logic into correctly timed bus cycles.
- Serves as a test driver for the FPGA register-file responder, and for talking to external SRAM or to a peer FPGA.
- Sits between a command source (sequencer or bench) and the FPGA bidirectional I/O cells; tristate control is exposed as a separate output-enable signal.

Parameters:
- ADDSET, 2: address/select setup cycles before the strobe (>=1).
- DATAST, 4: strobe (noe/nwe low) cycles (>=1).
- HOLD, 1: cycles after the strobe with select still low (>=1).
- TURN, 1: cycles with select high before the next command may be accepted (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  20  word address
- cmd_wdata  in  16  write data
- cmd_be  in  2  byte enables, active high; bit0=d[7:0], bit1=d[15:8]
- rsp_valid  out  1  one-cycle pulse at end of every completed cycle (read or write)
- rsp_rdata  out  16  read data; held until the next read completes
- bus_addr  out  20  address bus
- bus_dout  out  16  data driven to the pads
- bus_din  in  16  data from the pads
- bus_doe  out  1  pad output enable
- bus_ne  out  1  chip select, active low
- bus_noe  out  1  output enable strobe, active low
- bus_nwe  out  1  write strobe, active low
- bus_nbl  out  2  byte-lane enables, active low

Behaviour:
- All outputs are registered; no combinational path from bus_din to any output.
- Reset values: bus_ne=bus_noe=bus_nwe=1, bus_nbl=2'b11, bus_doe=0, bus_addr=0, bus_dout=0, rsp_valid=0, rsp_rdata=0, state=IDLE.
- cmd_ready = (state==IDLE) && !reset. The command is accepted at the edge where cmd_valid && cmd_ready.
- Captured at acceptance: write flag, address, write data, byte enables.
- FSM states: IDLE, SETUP, STROBE, HOLD, TURN. A down-counter reloads on each state entry.
- IDLE:
  - Accept a command, then go to SETUP.
  - Next cycle: bus_ne=0, bus_addr=cmd_addr.
  - bus_nbl = ~cmd_be for writes; 2'b00 for reads.
  - Writes: bus_dout=cmd_wdata and bus_doe=1 from SETUP onward.
- SETUP:
  - ADDSET cycles, strobes high, then go to STROBE.
- STROBE:
  - DATAST cycles: bus_noe=0 (read) or bus_nwe=0 (write).
  - Reads: bus_din is registered into rsp_rdata on the last STROBE cycle only.
- HOLD:
  - HOLD cycles with strobes high.
  - bus_ne, bus_addr and bus_nbl unchanged; bus_doe stays 1 for writes.
- TURN:
  - TURN cycles with bus_ne=1, bus_nbl=2'b11, bus_doe=0.
  - rsp_valid=1 on the first TURN cycle only.
  - Then return to IDLE.
- The TURN state guarantees select is high for >=1 cycle between consecutive accesses; responders depend on this to re-arm.
- Latency with defaults, acceptance at cycle 0:
  - SETUP cycles 1-2; STROBE cycles 3-6; HOLD cycle 7; TURN cycle 8 (rsp_valid); cmd_ready=1 at cycle 9.
  - Total = ADDSET+DATAST+HOLD+TURN+1 cycles per access.
- Inputs outside IDLE are ignored; changes to cmd_* after acceptance have no effect.
- A write with cmd_be=2'b00 runs a full cycle with bus_nbl=2'b11.
- Reset asserted in any state:
  - Next edge returns all outputs to reset values.
  - The in-flight command is dropped with no rsp_valid.
  - rsp_rdata is cleared.
- Counter width is $clog2 of the largest parameter + 1. Parameter values <1 are an elaboration error.

Decomposition:
- fmc_pkg holds:
  - the state enum;
  - FMC_ADDR_W=20 and FMC_DATA_W=16;
  - default timing constants shared with the responder and the bench.
- One natural sub-module, fmc_phase_counter: load value, decrement enable, `done` flag; instantiated once.

Test Plan:
- Read 0x00001, bench drives bus_din=0xBEEF during strobe.
  - rsp_valid at cycle 8, rsp_rdata=0xBEEF.
  - bus_ne=0 cycles 1-7, bus_noe=0 cycles 3-6, bus_nwe=1 throughout, bus_doe=0 throughout.
- Write 0x00002 with 0x1234, be=2'b11.
  - bus_nwe=0 cycles 3-6, bus_doe=1 cycles 1-7, bus_dout=0x1234, bus_nbl=2'b00, rsp_valid at cycle 8.
- Write with be=2'b01.
  - bus_nbl=2'b10 cycles 1-7, 2'b11 at cycle 8.
- cmd_valid held high with two back-to-back reads.
  - Second accepted at cycle 9.
  - bus_ne=1 at cycle 8 and cycle 9 between the accesses.
  - cmd_ready=0 during cycles 1-8.
- bus_din=0x0000 cycles 3-5, 0xA5A5 at cycle 6.
  - rsp_rdata=0xA5A5 (last-strobe sampling).
- Reset asserted at cycle 4 of a write.
  - Cycle 5: bus_ne=bus_nwe=1, bus_doe=0, bus_nbl=2'b11; no rsp_valid.
  - cmd_ready=1 on the first cycle after reset deasserts.
